// File: rtl/riscv_core_pkg.sv
// Shared core definitions: word size, canonical NOP and the fetch response payload.
package riscv_core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_resp_t;

  function automatic logic isMisaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Synchronous FIFO of fetch responses; clear drops every queued entry in one cycle.
module imem_resp_fifo
  import riscv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_resp_t                pushData,
  input  logic                       pop,
  output fetch_resp_t                headData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_resp_t     slots [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic            doPush;
  logic            doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPush   = push & ~full;
  assign doPop    = pop & ~empty;
  assign headData = slots[rdPtr];

  // Storage and pointers; slots reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        slots[wrPtr] <= pushData;
        wrPtr        <= nextPtr(wrPtr);
      end
      if (doPop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for fetch: fixed-latency read pipeline feeding a response FIFO.
// Optional misaligned-fetch reporting is enabled by defining IMEM_MISALIGN_CHK_EN.
module imem_fetch_responder
  import riscv_core_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned RESP_FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_instr,
  output logic [XLEN-1:0] resp_pc,
  output logic            resp_err,
  input  logic            ld_we,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned WAW = XLEN - 2;
  localparam int unsigned CW  = $clog2(RESP_FIFO_DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic            accept;
  logic            pop;
  logic            pushValid;
  logic            fifoEmpty;
  logic            fifoFull;
  logic [CW-1:0]   outCount;
  logic [CW-1:0]   fifoCount;
  fetch_resp_t     s0Data;
  fetch_resp_t     pushData;
  fetch_resp_t     headData;
  logic            unusedLdLsb;

  // Loader writes win over fetch; a full credit count blocks new requests.
  assign req_ready  = ~rst & ~flush & ~ld_we & (outCount < CW'(RESP_FIFO_DEPTH));
  assign accept     = req_valid & req_ready;
  assign resp_valid = ~fifoEmpty;
  assign pop        = resp_valid & resp_ready & ~flush;

  assign unusedLdLsb = ^ld_addr[1:0];

  // Program download; writes beyond the array are silently dropped.
  always_ff @(posedge clk) begin
    if (ld_we && (ld_addr[XLEN-1:2] < WAW'(DEPTH_WORDS))) begin
      mem[ld_addr[AW+1:2]] <= ld_data;
    end
  end

  // Response formed from the request in its accept cycle.
  always_comb begin
    s0Data.pc    = req_addr;
    s0Data.err   = 1'b0;
    s0Data.instr = (req_addr[XLEN-1:2] < WAW'(DEPTH_WORDS)) ? mem[req_addr[AW+1:2]] : NOP_INSTR;
`ifdef IMEM_MISALIGN_CHK_EN
    if (isMisaligned(req_addr)) begin
      s0Data.instr = NOP_INSTR;
      s0Data.err   = 1'b1;
    end
`endif
  end

  // LATENCY-1 register stages; the FIFO write is the final stage.
  if (LATENCY == 1) begin : gDirect
    assign pushValid = accept;
    assign pushData  = s0Data;
  end else begin : gPipe
    localparam int unsigned NS = LATENCY - 1;

    logic        stgValid [NS];
    fetch_resp_t stgData  [NS];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < NS; i++) begin
          stgValid[i] <= 1'b0;
        end
      end else if (flush) begin
        for (int unsigned i = 0; i < NS; i++) begin
          stgValid[i] <= 1'b0;
        end
      end else begin
        stgValid[0] <= accept;
        for (int unsigned i = 1; i < NS; i++) begin
          stgValid[i] <= stgValid[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      stgData[0] <= s0Data;
      for (int unsigned i = 1; i < NS; i++) begin
        stgData[i] <= stgData[i-1];
      end
    end

    assign pushValid = stgValid[NS-1];
    assign pushData  = stgData[NS-1];
  end

  // Outstanding credits cover both pipeline and FIFO, so the FIFO cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outCount <= '0;
    end else if (flush) begin
      outCount <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outCount <= outCount + CW'(1);
        2'b01:   outCount <= outCount - CW'(1);
        default: outCount <= outCount;
      endcase
    end
  end

  imem_resp_fifo #(
    .DEPTH (RESP_FIFO_DEPTH)
  ) uRespFifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (pushValid),
    .pushData (pushData),
    .pop      (pop),
    .headData (headData),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  assign resp_instr = headData.instr;
  assign resp_pc    = headData.pc;
  assign resp_err   = headData.err;

  noFifoOverflow: assert property (@(posedge clk) disable iff (rst) !(pushValid && fifoFull));
  fifoWithinCredit: assert property (@(posedge clk) disable iff (rst) fifoCount <= outCount);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_imem_fetch_responder;

  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int DW  = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WA  = 32'h1111_AAAA;
  localparam logic [31:0] WB  = 32'h2222_BBBB;
  localparam logic [31:0] WC  = 32'h3333_CCCC;
  localparam logic [31:0] WD  = 32'h4444_DDDD;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_pc;
  logic        resp_err;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        popLog[$];
  logic [31:0] shadow [DW];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  imem_fetch_responder #(
    .DEPTH_WORDS     (DW),
    .LATENCY         (LAT),
    .RESP_FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_pc    (resp_pc),
    .resp_err   (resp_err),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t predict(input logic [31:0] a, input int c);
    exp_t e;
    e.pc    = a;
    e.cyc   = c;
    e.err   = 1'b0;
    e.instr = (a >= 32'(DW * 4)) ? NOP : shadow[a[11:2]];
`ifdef IMEM_MISALIGN_CHK_EN
    if (a[1:0] != 2'b00) begin
      e.instr = NOP;
      e.err   = 1'b1;
    end
`endif
    return e;
  endfunction

  // Reference model: an oldest-first queue; head becomes visible LAT cycles after its accept.
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_instr !== 32'h0 ||
          resp_pc !== 32'h0 || resp_err !== 1'b0) begin
        bad++;
        $display("FAIL sb_reset_outputs cyc=%0d ready=%b valid=%b instr=%h pc=%h err=%b want all zero",
                 cyc, req_ready, resp_valid, resp_instr, resp_pc, resp_err);
      end
      q.delete();
    end else begin
      logic expValid, expReady;
      expValid = (q.size() > 0) && (cyc >= q[0].cyc + LAT);
      expReady = !flush && !ld_we && (q.size() < FD);
      total++;
      if (resp_valid !== expValid) begin
        bad++;
        $display("FAIL sb_resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, expValid);
      end
      total++;
      if (req_ready !== expReady) begin
        bad++;
        $display("FAIL sb_req_ready cyc=%0d got=%b want=%b", cyc, req_ready, expReady);
      end
      if (expValid && resp_valid === 1'b1) begin
        total++;
        if (resp_instr !== q[0].instr || resp_pc !== q[0].pc || resp_err !== q[0].err) begin
          bad++;
          $display("FAIL sb_resp_data cyc=%0d got instr=%h pc=%h err=%b want instr=%h pc=%h err=%b",
                   cyc, resp_instr, resp_pc, resp_err, q[0].instr, q[0].pc, q[0].err);
        end
      end
      if (resp_valid === 1'b1 && resp_ready && !flush) begin
        exp_t o;
        o.instr = resp_instr;
        o.pc    = resp_pc;
        o.err   = resp_err;
        o.cyc   = cyc;
        popLog.push_back(o);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (expValid && resp_ready) void'(q.pop_front());
        if (expReady && req_valid) q.push_back(predict(req_addr, cyc));
      end
      if (ld_we && ld_addr < 32'(DW * 4)) shadow[ld_addr[11:2]] = ld_data;
    end
  end

  task automatic issue(input logic [31:0] a, output int acc);
    req_valid = 1'b1;
    req_addr  = a;
    acc       = -1;
    for (int k = 0; k < 64 && acc < 0; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) acc = cyc;
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL issue_timeout addr=%h never accepted", a);
    end
    req_valid = 1'b0;
  endtask

  task automatic waitPops(input int n, input int maxCyc);
    for (int k = 0; k < maxCyc && popLog.size() < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    repeat (2) @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++;
    if (resp_instr !== 32'h0 || resp_pc !== 32'h0 || resp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_resp_data got instr=%h pc=%h err=%b want 0/0/0", resp_instr, resp_pc, resp_err);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic load_program;
    for (int i = 0; i < DW; i++) begin
      ld_we   = 1'b1;
      ld_addr = 32'(i * 4);
      case (i)
        0: ld_data = WA;
        1: ld_data = WB;
        2: ld_data = WC;
        3: ld_data = WD;
        default: ld_data = $urandom;
      endcase
      @(posedge clk); #1;
    end
    ld_we = 1'b0;
  endtask

  task automatic test_back_to_back;
    int acc0, a;
    logic [31:0] expI [4];
    expI[0] = WA; expI[1] = WB; expI[2] = WC; expI[3] = WD;
    resp_ready = 1'b1;
    popLog.delete();
    issue(32'h0, acc0);
    issue(32'h4, a);
    issue(32'h8, a);
    issue(32'hC, a);
    total++;
    if (a !== acc0 + 3) begin bad++; $display("FAIL b2b_accept_span got=%0d want=%0d", a - acc0, 3); end
    waitPops(4, 20);
    total++;
    if (popLog.size() !== 4) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=4", popLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (popLog[i].instr !== expI[i] || popLog[i].pc !== 32'(i * 4) || popLog[i].err !== 1'b0) begin
          bad++;
          $display("FAIL b2b_resp%0d got instr=%h pc=%h want instr=%h pc=%h",
                   i, popLog[i].instr, popLog[i].pc, expI[i], 32'(i * 4));
        end
      end
      total++;
      if (popLog[0].cyc - acc0 !== LAT) begin
        bad++;
        $display("FAIL b2b_latency got=%0d want=%0d", popLog[0].cyc - acc0, LAT);
      end
    end
  endtask

  task automatic test_backpressure;
    int accepted = 0;
    resp_ready = 1'b0;
    popLog.delete();
    req_valid = 1'b1;
    req_addr  = 32'h100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) accepted++;
      @(posedge clk); #1;
      req_addr = 32'h100 + 32'(accepted * 4);
    end
    @(negedge clk);
    total++;
    if (accepted !== 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", accepted); end
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_when_full got=%b want=0", req_ready); end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    waitPops(4, 20);
    total++;
    if (popLog.size() !== 4) begin
      bad++;
      $display("FAIL bp_drain_count got=%0d want=4", popLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (popLog[i].instr !== shadow[64 + i] || popLog[i].pc !== 32'h100 + 32'(i * 4)) begin
          bad++;
          $display("FAIL bp_resp%0d got instr=%h pc=%h want instr=%h pc=%h",
                   i, popLog[i].instr, popLog[i].pc, shadow[64 + i], 32'h100 + 32'(i * 4));
        end
      end
    end
  endtask

  task automatic test_flush;
    int a;
    resp_ready = 1'b1;
    popLog.delete();
    issue(32'h0, a);
    issue(32'h4, a);
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL flush_valid_after got=%b want=0", resp_valid); end
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (popLog.size() !== 0) begin bad++; $display("FAIL flush_dropped got=%0d pops want=0", popLog.size()); end
    popLog.delete();
    issue(32'h8, a);
    waitPops(1, 20);
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (popLog.size() !== 1) begin
      bad++;
      $display("FAIL flush_after_count got=%0d want=1", popLog.size());
    end else begin
      total++;
      if (popLog[0].instr !== WC || popLog[0].pc !== 32'h8) begin
        bad++;
        $display("FAIL flush_after_resp got instr=%h pc=%h want instr=%h pc=%h",
                 popLog[0].instr, popLog[0].pc, WC, 32'h8);
      end
    end
  endtask

  task automatic test_loader;
    int a;
    resp_ready = 1'b1;
    popLog.delete();
    req_valid = 1'b1;
    req_addr  = 32'h4;
    ld_we     = 1'b1;
    ld_addr   = 32'h4;
    ld_data   = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL ld_blocks_ready got=%b want=0", req_ready); end
    @(posedge clk); #1;
    ld_we = 1'b0;
    issue(32'h4, a);
    waitPops(1, 20);
    total++;
    if (popLog.size() < 1 || popLog[0].instr !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL ld_new_word got=%h want=deadbeef", (popLog.size() > 0) ? popLog[0].instr : 32'hx);
    end
  endtask

  task automatic test_out_of_range;
    int a;
    resp_ready = 1'b1;
    popLog.delete();
    ld_we   = 1'b1;
    ld_addr = 32'h1000;
    ld_data = 32'h1234_5678;
    @(posedge clk); #1;
    ld_we = 1'b0;
    issue(32'h1000, a);
    issue(32'h0, a);
    issue(32'hFFC, a);
    waitPops(3, 20);
    total++;
    if (popLog.size() !== 3) begin
      bad++;
      $display("FAIL oor_count got=%0d want=3", popLog.size());
    end else begin
      total++;
      if (popLog[0].instr !== NOP || popLog[0].err !== 1'b0 || popLog[0].pc !== 32'h1000) begin
        bad++;
        $display("FAIL oor_nop got instr=%h err=%b pc=%h want instr=%h err=0 pc=00001000",
                 popLog[0].instr, popLog[0].err, popLog[0].pc, NOP);
      end
      total++;
      if (popLog[1].instr !== WA) begin
        bad++;
        $display("FAIL oor_write_dropped got=%h want=%h", popLog[1].instr, WA);
      end
      total++;
      if (popLog[2].instr !== shadow[DW - 1]) begin
        bad++;
        $display("FAIL oor_last_word got=%h want=%h", popLog[2].instr, shadow[DW - 1]);
      end
    end
  endtask

  task automatic test_misalign;
    int a;
    logic [31:0] wantI;
    logic        wantE;
`ifdef IMEM_MISALIGN_CHK_EN
    wantI = NOP;
    wantE = 1'b1;
`else
    wantI = shadow[1];
    wantE = 1'b0;
`endif
    resp_ready = 1'b1;
    popLog.delete();
    issue(32'h6, a);
    waitPops(1, 20);
    total++;
    if (popLog.size() < 1 || popLog[0].instr !== wantI || popLog[0].err !== wantE || popLog[0].pc !== 32'h6) begin
      bad++;
      $display("FAIL misalign got instr=%h err=%b pc=%h want instr=%h err=%b pc=00000006",
               (popLog.size() > 0) ? popLog[0].instr : 32'hx, (popLog.size() > 0) ? popLog[0].err : 1'bx,
               (popLog.size() > 0) ? popLog[0].pc : 32'hx, wantI, wantE);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 500; k++) begin
      req_valid  = ($urandom_range(0, 99) < 60);
      req_addr   = 32'($urandom_range(0, 1100)) << 2;
      if ($urandom_range(0, 9) == 0) req_addr[1:0] = 2'($urandom_range(1, 3));
      resp_ready = ($urandom_range(0, 99) < 65);
      flush      = ($urandom_range(0, 99) < 3);
      ld_we      = ($urandom_range(0, 99) < 5);
      ld_addr    = 32'($urandom_range(0, 1100)) << 2;
      ld_data    = $urandom;
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    flush      = 1'b0;
    ld_we      = 1'b0;
    resp_ready = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL rand_drained got=%b want=0", resp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int a;
    resp_ready = 1'b0;
    issue(32'h20, a);
    issue(32'h24, a);
    popLog.delete();
    rst       = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs got valid=%b ready=%b want 0/0", resp_valid, req_ready);
    end
    @(posedge clk); #1;
    rst        = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    total++;
    if (popLog.size() !== 0) begin bad++; $display("FAIL midrst_lost got=%0d pops want=0", popLog.size()); end
    issue(32'h28, a);
    waitPops(1, 20);
    total++;
    if (popLog.size() < 1 || popLog[0].pc !== 32'h28 || popLog[0].instr !== shadow[10]) begin
      bad++;
      $display("FAIL midrst_resume got pc=%h instr=%h want pc=00000028 instr=%h",
               (popLog.size() > 0) ? popLog[0].pc : 32'hx, (popLog.size() > 0) ? popLog[0].instr : 32'hx,
               shadow[10]);
    end
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = 32'h0;
    ld_data    = 32'h0;
    #2;
    test_reset();
    load_program();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_loader();
    test_out_of_range();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
